// File: rtl/arm_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Holds the FSM state enum, ALU control codes, datapath mux encodings,
// instruction field codes and the ARM condition-code constants.
package arm_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StBranch
   } state_t;

   // ALU control
   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluOrr = 2'b11;

   // Memory address source
   localparam logic AdrPc     = 1'b0;
   localparam logic AdrAluOut = 1'b1;

   // ALU operand A source
   localparam logic SrcARd1 = 1'b0;
   localparam logic SrcAPc  = 1'b1;

   // ALU operand B source
   localparam logic [1:0] SrcBRd2    = 2'b00;
   localparam logic [1:0] SrcBExtImm = 2'b01;
   localparam logic [1:0] SrcBFour   = 2'b10;

   // Result bus source
   localparam logic [1:0] ResAluOut = 2'b00;
   localparam logic [1:0] ResData   = 2'b01;
   localparam logic [1:0] ResAlu    = 2'b10;

   // Immediate extension format
   localparam logic [1:0] ImmDp     = 2'b00;
   localparam logic [1:0] ImmMem    = 2'b01;
   localparam logic [1:0] ImmBranch = 2'b10;

   // Instruction class (instr[27:26])
   localparam logic [1:0] OpDp     = 2'b00;
   localparam logic [1:0] OpMem    = 2'b01;
   localparam logic [1:0] OpBranch = 2'b10;

   // Data-processing commands (funct[4:1])
   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdOrr = 4'b1100;

   // Condition codes (instr[31:28])
   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondCs = 4'b0010;
   localparam logic [3:0] CondCc = 4'b0011;
   localparam logic [3:0] CondMi = 4'b0100;
   localparam logic [3:0] CondPl = 4'b0101;
   localparam logic [3:0] CondVs = 4'b0110;
   localparam logic [3:0] CondVc = 4'b0111;
   localparam logic [3:0] CondHi = 4'b1000;
   localparam logic [3:0] CondLs = 4'b1001;
   localparam logic [3:0] CondGe = 4'b1010;
   localparam logic [3:0] CondLt = 4'b1011;
   localparam logic [3:0] CondGt = 4'b1100;
   localparam logic [3:0] CondLe = 4'b1101;
   localparam logic [3:0] CondAl = 4'b1110;
   localparam logic [3:0] CondNv = 4'b1111;

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register and condition check.
// Ports:
//   clk, n_reset   clock, asynchronous active-low reset
//   cond           instruction condition field
//   alu_flags      NZCV from the ALU this cycle
//   flag_w         [1] load N,Z  [0] load C,V (qualified here by cond_ex)
//   cond_ex        condition passes against the registered flags
module cond_logic
   import arm_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);

   logic [3:0] flags_q, flags_d;
   logic       n_f, z_f, c_f, v_f;

   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         CondEq:  cond_ex = z_f;
         CondNe:  cond_ex = ~z_f;
         CondCs:  cond_ex = c_f;
         CondCc:  cond_ex = ~c_f;
         CondMi:  cond_ex = n_f;
         CondPl:  cond_ex = ~n_f;
         CondVs:  cond_ex = v_f;
         CondVc:  cond_ex = ~v_f;
         CondHi:  cond_ex = c_f & ~z_f;
         CondLs:  cond_ex = ~c_f | z_f;
         CondGe:  cond_ex = (n_f == v_f);
         CondLt:  cond_ex = (n_f != v_f);
         CondGt:  cond_ex = ~z_f & (n_f == v_f);
         CondLe:  cond_ex = z_f | (n_f != v_f);
         CondAl:  cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // A failed condition suppresses the flag update as well as the writes.
   always_comb begin
      flags_d = flags_q;
      if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) flags_q <= FLAG_RESET;
      else          flags_q <= flags_d;
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle ARM core.
// Sequences fetch, decode, execute, memory and write-back over one shared
// memory port and one ALU; owns the NZCV flags through cond_logic.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   op, funct, rd, cond   fields of the latched instruction register
//   alu_flags             NZCV from the ALU
//   mem_ready             memory access completes this cycle
//   pc_w, ir_w, reg_w, mem_w   write enables (all 0 while in reset)
//   adr_src, alu_src_a, alu_src_b, result_src, imm_src, reg_src  mux selects
//   alu_control           00 ADD, 01 SUB, 10 AND, 11 ORR
module multicycle_controller
   import arm_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic       mem_ready,
   output logic       pc_w,
   output logic       ir_w,
   output logic       reg_w,
   output logic       mem_w,
   output logic       adr_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [1:0] alu_control
);

   state_t     state_q, state_d;
   logic       cond_ex;
   logic [1:0] flag_w;
   logic [3:0] cmd;
   logic       s_bit;
   logic       pc_w_s, ir_w_s, reg_w_s, mem_w_s;
   logic       rd_is_pc;

   assign cmd      = funct[4:1];
   assign s_bit    = funct[0];
   assign rd_is_pc = (rd == 4'd15);

   cond_logic #(
      .FLAG_RESET (FLAG_RESET)
   ) u_cond_logic (
      .clk       (clk),
      .n_reset   (n_reset),
      .cond      (cond),
      .alu_flags (alu_flags),
      .flag_w    (flag_w),
      .cond_ex   (cond_ex)
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= StFetch;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:    if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (op)
               OpDp:     state_d = funct[5] ? StExecuteI : StExecuteR;
               OpMem:    state_d = StMemAdr;
               OpBranch: state_d = StBranch;
               default:  state_d = StFetch;
            endcase
         end
         StExecuteR: state_d = StAluWb;
         StExecuteI: state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StMemAdr:   state_d = funct[0] ? StMemRead : StMemWrite;
         StMemRead:  if (mem_ready) state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: if (mem_ready) state_d = StFetch;
         StBranch:   state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   // ALU decode; flag_w is raised only in the execute states, so the flag
   // register can only change on the edge that leaves them.
   always_comb begin
      alu_control = AluAdd;
      flag_w      = 2'b00;
      if (state_q == StExecuteR || state_q == StExecuteI) begin
         case (cmd)
            CmdAdd: begin
               alu_control = AluAdd;
               flag_w      = {s_bit, s_bit};
            end
            CmdSub: begin
               alu_control = AluSub;
               flag_w      = {s_bit, s_bit};
            end
            CmdAnd: begin
               alu_control = AluAnd;
               flag_w      = {s_bit, 1'b0};
            end
            CmdOrr: begin
               alu_control = AluOrr;
               flag_w      = {s_bit, 1'b0};
            end
            default: begin
               alu_control = AluAdd;
               flag_w      = 2'b00;
            end
         endcase
      end
   end

   // Moore outputs per state
   always_comb begin
      pc_w_s     = 1'b0;
      ir_w_s     = 1'b0;
      reg_w_s    = 1'b0;
      mem_w_s    = 1'b0;
      adr_src    = AdrPc;
      alu_src_a  = SrcARd1;
      alu_src_b  = SrcBRd2;
      result_src = ResAluOut;
      case (state_q)
         StFetch: begin
            alu_src_a  = SrcAPc;
            alu_src_b  = SrcBFour;
            result_src = ResAlu;
            ir_w_s     = mem_ready;
            pc_w_s     = mem_ready;
         end
         StDecode: begin
            // PC+8 onto the result bus for R15 reads
            alu_src_a  = SrcAPc;
            alu_src_b  = SrcBFour;
            result_src = ResAlu;
         end
         StExecuteR: alu_src_b = SrcBRd2;
         StExecuteI: alu_src_b = SrcBExtImm;
         StAluWb: begin
            result_src = ResAluOut;
            reg_w_s    = cond_ex;
            pc_w_s     = cond_ex & rd_is_pc;
         end
         StMemAdr:   alu_src_b = funct[5] ? SrcBRd2 : SrcBExtImm;
         StMemRead:  adr_src   = AdrAluOut;
         StMemWb: begin
            result_src = ResData;
            reg_w_s    = cond_ex;
            pc_w_s     = cond_ex & rd_is_pc;
         end
         StMemWrite: begin
            adr_src = AdrAluOut;
            mem_w_s = cond_ex;
         end
         StBranch: begin
            alu_src_a  = SrcARd1;
            alu_src_b  = SrcBExtImm;
            result_src = ResAlu;
            pc_w_s     = cond_ex;
         end
         default: ;
      endcase
   end

   // Reset forces every architectural write off even though FETCH would
   // otherwise follow mem_ready combinationally.
   assign pc_w  = pc_w_s & n_reset;
   assign ir_w  = ir_w_s & n_reset;
   assign reg_w = reg_w_s & n_reset;
   assign mem_w = mem_w_s & n_reset;

   assign imm_src = {op == OpBranch, op == OpMem};
   assign reg_src = {(op == OpMem) & ~funct[0], op == OpBranch};

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: each row is one clock cycle
// of inputs plus the expected state-dependent outputs.
module tb_multicycle_controller;

   typedef enum int {PhF, PhD, PhEr, PhEi, PhAw, PhMar, PhMai, PhMr, PhMb, PhMw, PhBr} ph_e;

   typedef struct {
      logic       rst_n;
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic [3:0] cond;
      logic [3:0] aflags;
      logic       mrdy;
      ph_e        ph;
      logic [3:0] en;   // {pc_w, ir_w, reg_w, mem_w}
      logic [1:0] alu;
   } vec_t;

   logic       clk = 1'b0;
   logic       n_reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd, cond, alu_flags;
   logic       mem_ready;
   logic       pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a;
   logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control;

   vec_t        vecs[$];
   logic [15:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   logic       c_rst;
   logic [1:0] c_op;
   logic [5:0] c_funct;
   logic [3:0] c_rd, c_cond, c_flags;

   always #5 clk = ~clk;

   multicycle_controller #(
      .FLAG_RESET (4'b0000)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .op          (op),
      .funct       (funct),
      .rd          (rd),
      .cond        (cond),
      .alu_flags   (alu_flags),
      .mem_ready   (mem_ready),
      .pc_w        (pc_w),
      .ir_w        (ir_w),
      .reg_w       (reg_w),
      .mem_w       (mem_w),
      .adr_src     (adr_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .imm_src     (imm_src),
      .reg_src     (reg_src),
      .alu_control (alu_control)
   );

   // {adr_src, alu_src_a, alu_src_b, result_src} per state
   function automatic logic [5:0] sel_of(input ph_e ph);
      case (ph)
         PhF, PhD:  return 6'b0_1_10_10;
         PhEi, PhMai: return 6'b0_0_01_00;
         PhMr, PhMw: return 6'b1_0_00_00;
         PhMb:      return 6'b0_0_00_01;
         PhBr:      return 6'b0_0_01_10;
         default:   return 6'b0_0_00_00;
      endcase
   endfunction

   function automatic logic [15:0] exp_word(input vec_t v);
      logic [1:0] imm;
      logic [1:0] rs;
      imm = {v.op == 2'b10, v.op == 2'b01};
      rs  = {(v.op == 2'b01) && !v.funct[0], v.op == 2'b10};
      return {v.en, sel_of(v.ph), imm, rs, v.alu};
   endfunction

   task automatic instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                        input logic [3:0] c, input logic [3:0] fl);
      c_op = o; c_funct = f; c_rd = r; c_cond = c; c_flags = fl;
   endtask

   task automatic step(input ph_e ph, input logic [3:0] en, input logic [1:0] alu = 2'b00,
                       input logic mrdy = 1'b1);
      vec_t v;
      v.rst_n = c_rst; v.op = c_op; v.funct = c_funct; v.rd = c_rd; v.cond = c_cond;
      v.aflags = c_flags; v.mrdy = mrdy; v.ph = ph; v.en = en; v.alu = alu;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic [15:0] got;
      logic [15:0] exp;
      @(negedge clk);
      n_reset = v.rst_n; op = v.op; funct = v.funct; rd = v.rd; cond = v.cond;
      alu_flags = v.aflags; mem_ready = v.mrdy;
      sb.push_back(exp_word(v));
      #2;
      got = {pc_w, ir_w, reg_w, mem_w, adr_src, alu_src_a, alu_src_b, result_src,
             imm_src, reg_src, alu_control};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL row %0d (%s): outputs got %h expected %h", idx, v.ph.name(), got, exp);
      end
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
      vecs.delete();
   endtask

   initial begin
      n_reset = 1'b0; op = '0; funct = '0; rd = '0; cond = '0; alu_flags = '0;
      mem_ready = 1'b1;

      // Main table, flags start at 0000
      c_rst = 1'b0;
      instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
      step(PhF, 4'b0000);
      c_rst = 1'b1;
      // BEQ with Z=0: not taken
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      // ADDS R1,R2,#5 -> flags 0110
      instr(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b0110);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEi, 4'b0000, 2'b00);
      step(PhAw, 4'b0010);
      // BEQ now taken, BMI not
      instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b1000);
      instr(2'b10, 6'b100000, 4'd0, 4'b0100, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      // SUB R15: pc_w and reg_w together
      instr(2'b00, 6'b000100, 4'd15, 4'b1110, 4'b1111);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEr, 4'b0000, 2'b01);
      step(PhAw, 4'b1010);
      // cmd 1010 with S: ADD, no flag update
      instr(2'b00, 6'b010101, 4'd2, 4'b1110, 4'b1001);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEr, 4'b0000, 2'b00);
      step(PhAw, 4'b0010);
      instr(2'b10, 6'b100000, 4'd0, 4'b0100, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      // ORRS loads N,Z only: flags 0110 -> 1010
      instr(2'b00, 6'b011001, 4'd4, 4'b1110, 4'b1011);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEr, 4'b0000, 2'b11);
      step(PhAw, 4'b0010);
      instr(2'b10, 6'b100000, 4'd0, 4'b0110, 4'b0000);  // BVS: V kept 0
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      instr(2'b10, 6'b100000, 4'd0, 4'b0100, 4'b0000);  // BMI: N=1
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b1000);
      // ANDSEQ with Z=0: full path, no write, no flag update
      instr(2'b00, 6'b000001, 4'd5, 4'b0000, 4'b0100);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEr, 4'b0000, 2'b10);
      step(PhAw, 4'b0000);
      instr(2'b10, 6'b100000, 4'd0, 4'b0001, 4'b0000);  // BNE taken
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b1000);
      instr(2'b10, 6'b100000, 4'd0, 4'b1100, 4'b0000);  // BGT: N!=V
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      instr(2'b10, 6'b100000, 4'd0, 4'b1011, 4'b0000);  // BLT
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b1000);
      instr(2'b10, 6'b100000, 4'd0, 4'b1000, 4'b0000);  // BHI: C & ~Z
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b1000);
      instr(2'b10, 6'b100000, 4'd0, 4'b1111, 4'b0000);  // cond 1111 never
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      // LDR with two wait cycles: 7 cycles
      instr(2'b01, 6'b011001, 4'd3, 4'b1110, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMai, 4'b0000);
      step(PhMr, 4'b0000, 2'b00, 1'b0); step(PhMr, 4'b0000, 2'b00, 1'b0);
      step(PhMr, 4'b0000); step(PhMb, 4'b0010);
      // STR register offset, one wait cycle: mem_w held 2 cycles
      instr(2'b01, 6'b111000, 4'd6, 4'b1110, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMar, 4'b0000);
      step(PhMw, 4'b0001, 2'b00, 1'b0); step(PhMw, 4'b0001);
      // STREQ failing: no strobe
      instr(2'b01, 6'b011000, 4'd6, 4'b0000, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMai, 4'b0000); step(PhMw, 4'b0000);
      // Undefined op: 2 cycles
      instr(2'b11, 6'b000000, 4'd0, 4'b1110, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000);
      // B with a fetch wait
      instr(2'b10, 6'b100000, 4'd0, 4'b1110, 4'b0000);
      step(PhF, 4'b0000, 2'b00, 1'b0); step(PhF, 4'b1100); step(PhD, 4'b0000);
      step(PhBr, 4'b1000);
      // LDR into R15
      instr(2'b01, 6'b011001, 4'd15, 4'b1110, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMai, 4'b0000);
      step(PhMr, 4'b0000); step(PhMb, 4'b1010);
      run_table();

      // Reset in DECODE: flags return to 0000, instruction abandoned
      instr(2'b00, 6'b101001, 4'd1, 4'b1110, 4'b0100);  // ADDS -> Z=1
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhEi, 4'b0000); step(PhAw, 4'b0010);
      instr(2'b10, 6'b100000, 4'd0, 4'b0000, 4'b0000);  // BEQ
      step(PhF, 4'b1100); step(PhD, 4'b0000);
      c_rst = 1'b0;
      step(PhF, 4'b0000); step(PhF, 4'b0000);
      c_rst = 1'b1;
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhBr, 4'b0000);
      // Reset while a store is waiting: strobe drops at once
      instr(2'b01, 6'b011000, 4'd7, 4'b1110, 4'b0000);
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMai, 4'b0000);
      step(PhMw, 4'b0001, 2'b00, 1'b0);
      c_rst = 1'b0;
      step(PhF, 4'b0000);
      c_rst = 1'b1;
      step(PhF, 4'b1100); step(PhD, 4'b0000); step(PhMai, 4'b0000); step(PhMw, 4'b0001);
      step(PhF, 4'b1100);
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
